// File: rtl/sms32_inv_pkg.sv
// Shared types, constants and basis-change/squaring matrices for the x^40 S-box inverse.
// Field: GF(2^6) polynomial basis mod x^6+x+1 <-> tower GF((2^3)^2), GF(2^3) in normal basis.
package sms32_inv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2,
    CHK  = 2'd3
  } state_t;

  // Column j of a matrix is the image of basis vector j.
  typedef logic [5:0][5:0] mat6_t;

  localparam logic [5:0] EXP_DEFAULT = 6'd52;
  // Tower element {hi, lo}: value = hi*z + lo, with z^2 = z + nu.
  // GF(2^3) normal basis {g, g^2, g^4}, g a root of y^3+y^2+1, so one = (1,1,1).
  localparam logic [5:0] TOWER_ONE = 6'h07;
  localparam logic [2:0] GF8_NU    = 3'b001;
  localparam logic [2:0] ITER_LAST = 3'd6;

  function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
    logic t01, t02, t12;
    t01 = (a[0] & b[1]) ^ (a[1] & b[0]);
    t02 = (a[0] & b[2]) ^ (a[2] & b[0]);
    t12 = (a[1] & b[2]) ^ (a[2] & b[1]);
    return {(a[1] & b[1]) ^ t01 ^ t02,
            (a[0] & b[0]) ^ t02 ^ t12,
            (a[2] & b[2]) ^ t01 ^ t12};
  endfunction

  function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
    logic [2:0] hh;
    hh = gf8_mul(a[5:3], b[5:3]);
    return {hh ^ gf8_mul(a[5:3], b[2:0]) ^ gf8_mul(a[2:0], b[5:3]),
            gf8_mul(hh, GF8_NU) ^ gf8_mul(a[2:0], b[2:0])};
  endfunction

  function automatic logic [5:0] mat_vec(input mat6_t m, input logic [5:0] v);
    logic [5:0] r;
    r = '0;
    for (int j = 0; j < 6; j++) begin
      if (v[j]) r = r ^ m[j];
    end
    return r;
  endfunction

  // Matrix of x -> x^(2^n) in the tower basis.
  function automatic mat6_t sq_mat(input int n);
    mat6_t      m;
    logic [5:0] v;
    for (int j = 0; j < 6; j++) begin
      v    = '0;
      v[j] = 1'b1;
      for (int i = 0; i < n; i++) v = gf64_mul(v, v);
      m[j] = v;
    end
    return m;
  endfunction

  // Polynomial x^i maps to beta^i, beta a tower root of x^6+x+1.
  function automatic mat6_t iso_mat();
    mat6_t      m;
    logic [5:0] beta, t1, t2, t4, pw;
    beta = '0;
    for (int t = 63; t > 0; t--) begin
      t1 = 6'(t);
      t2 = gf64_mul(t1, t1);
      t4 = gf64_mul(t2, t2);
      if ((gf64_mul(t4, t2) ^ t1 ^ TOWER_ONE) == 6'h00) beta = t1;
    end
    pw = TOWER_ONE;
    for (int i = 0; i < 6; i++) begin
      m[i] = pw;
      pw   = gf64_mul(pw, beta);
    end
    return m;
  endfunction

  function automatic mat6_t inv_mat(input mat6_t fwd);
    mat6_t      m;
    logic [5:0] e, v;
    m = '0;
    for (int j = 0; j < 6; j++) begin
      e    = '0;
      e[j] = 1'b1;
      for (int i = 0; i < 64; i++) begin
        v = 6'(i);
        if (mat_vec(fwd, v) == e) m[j] = v;
      end
    end
    return m;
  endfunction

  localparam mat6_t ISO_MAT     = iso_mat();
  localparam mat6_t INV_ISO_MAT = inv_mat(ISO_MAT);
  localparam mat6_t SQ_MAT      = sq_mat(1);

endpackage

// File: rtl/sms32_40_pn_5_3_inv_seq_mul.sv
// Combinational GF((2^3)^2) multiplier: (ah*z+al)(bh*z+bl) with z^2 = z + nu.
module gf64_tower_mul
  import sms32_inv_pkg::*;
(
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] p
);

  logic [2:0] hh, hl, lh, ll;

  assign hh = gf8_mul(a[5:3], b[5:3]);
  assign hl = gf8_mul(a[5:3], b[2:0]);
  assign lh = gf8_mul(a[2:0], b[5:3]);
  assign ll = gf8_mul(a[2:0], b[2:0]);
  assign p  = {hh ^ hl ^ lh, gf8_mul(hh, GF8_NU) ^ ll};

endmodule

// File: rtl/sms32_40_pn_5_3_inv_seq.sv
// Sequential inverse of the x^40 S-box: square-and-multiply x^EXP in the tower field, 7-cycle latency.
// Optional self-check (macro SMS32_INV_SELFCHECK_EN) re-applies x^40 and flags err, adding one cycle.
module sms32_40_pn_5_3_inv_seq
  import sms32_inv_pkg::*;
#(
  parameter logic [5:0] EXP = EXP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_data,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] EXP_EXT = {2'b00, EXP};

  state_t     state, state_nxt;
  logic [5:0] sq, acc;
  logic [2:0] k;
  logic [5:0] mul_a, mul_b, mul_p;
  logic       exp_bit;

  assign exp_bit = EXP_EXT[k];

  gf64_tower_mul u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = COMP;
      end
      COMP: begin
        busy = 1'b1;
`ifdef SMS32_INV_SELFCHECK_EN
        if (k == ITER_LAST) state_nxt = CHK;
`else
        if (k == ITER_LAST) state_nxt = DONE;
`endif
      end
`ifdef SMS32_INV_SELFCHECK_EN
      CHK: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The last COMP cycle (k == ITER_LAST) only maps the finished accumulator back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq       <= '0;
      acc      <= '0;
      k        <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sq  <= mat_vec(ISO_MAT, in_data);
            acc <= TOWER_ONE;
            k   <= '0;
          end
        end
        COMP: begin
          if (k != ITER_LAST) begin
            if (exp_bit) acc <= mul_p;
            sq <= mat_vec(SQ_MAT, sq);
            k  <= k + 3'd1;
          end else begin
            out_data <= mat_vec(INV_ISO_MAT, acc);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SMS32_INV_SELFCHECK_EN
  localparam mat6_t SQ8_MAT  = sq_mat(3);
  localparam mat6_t SQ32_MAT = sq_mat(5);

  logic [5:0] in_q, res_t;

  assign res_t = mat_vec(ISO_MAT, out_data);

  // In CHK the shared multiplier forms r^32 * r^8 = r^40 of the registered result.
  always_comb begin
    mul_a = acc;
    mul_b = sq;
    if (state == CHK) begin
      mul_a = mat_vec(SQ32_MAT, res_t);
      mul_b = mat_vec(SQ8_MAT, res_t);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) in_q <= in_data;
      if (state == CHK) err <= (mat_vec(INV_ISO_MAT, mul_p) != in_q);
    end
  end
`else
  assign mul_a = acc;
  assign mul_b = sq;
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_sms32_40_pn_5_3_inv_seq.sv
// Scoreboard bench for sms32_40_pn_5_3_inv_seq against a GF(2^6) polynomial-basis power model.
module tb_sms32_40_pn_5_3_inv_seq;

`ifdef SMS32_INV_SELFCHECK_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 7;
`endif

  typedef struct packed {
    logic [5:0] d;
    logic       e;
  } exp_t;

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy, err;
  logic [5:0] in_data, out_data;

  exp_t exp_q[$];
  int   edge_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic seen_rise = 1'b0;
  logic [5:0] hold_d;
  logic hold_e;
  logic rand_rdy = 1'b0;
  logic rdy_fix = 1'b1;

  sms32_40_pn_5_3_inv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Reference: plain polynomial arithmetic modulo x^6 + x + 1.
  function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ x;
      x = x[5] ? ({x[4:0], 1'b0} ^ 6'h03) : {x[4:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [5:0] gpow(input logic [5:0] a, input int n);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < n; i++) r = gmul(r, a);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic send(input logic [5:0] d, input logic [5:0] e, input logic eerr);
    int   guard;
    exp_t x;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", in_ready, 1);
    if (in_ready) begin
      x.d = e;
      x.e = eerr;
      exp_q.push_back(x);
      edge_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 6'($urandom);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: latency on rise, hold stability under backpressure, data/err on handshake.
  initial begin
    exp_t x;
    int   t;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!seen_rise) begin
          seen_rise = 1'b1;
          hold_d    = out_data;
          hold_e    = err;
          chk("pending_accept", int'(edge_q.size() > 0), 1);
          if (edge_q.size() > 0) begin
            t = edge_q.pop_front();
            chk("latency", cyc - t, LAT);
          end
        end else begin
          chk("hold_data", out_data, hold_d);
          chk("hold_err", err, hold_e);
          chk("done_in_ready", in_ready, 0);
        end
        if (out_ready) begin
          seen_rise = 1'b0;
          chk("result_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("out_data", out_data, x.d);
            chk("err", err, x.e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] d;
    int guard;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 6'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);

    // Zero input: no special case, result zero.
    send(6'h00, 6'h00, 1'b0);
    chk("comp_busy", busy, 1);
    chk("comp_in_ready", in_ready, 0);
    wait_drain();

    // Sweep all forward S-box outputs; inverse must recover x.
    for (int x = 0; x < 64; x++) begin
      d = 6'(x);
      send(gpow(d, 40), d, 1'b0);
    end
    wait_drain();

    // Backpressure: result held for 5 cycles, extra in_valid ignored.
    rdy_fix = 1'b0;
    @(negedge clk);
    send(6'h2d, gpow(6'h2d, 52), 1'b0);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 6'h11;
    repeat (5) @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    rdy_fix  = 1'b1;
    wait_drain();
    repeat (12) @(negedge clk);
    chk("bp_ignored", out_valid, 0);
    chk("bp_idle", in_ready, 1);

    // Reset during COMP aborts the operation.
    send(6'h3a, gpow(6'h3a, 52), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    edge_q.delete();
    seen_rise = 1'b0;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(gpow(6'h15, 40), 6'h15, 1'b0);
    wait_drain();

    // Random words with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 6'($urandom);
      send(d, gpow(d, 52), 1'b0);
    end
    rand_rdy = 1'b0;
    rdy_fix  = 1'b1;
    repeat (2) @(negedge clk);
    wait_drain();

`ifdef SMS32_INV_SELFCHECK_EN
    // Corrupt the accumulator just before the result is mapped back.
    send(gpow(6'h05, 40), 6'h00, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    force dut.acc = 6'h00;
    @(posedge clk);
    #1;
    release dut.acc;
    wait_drain();
`endif

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size() + edge_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
